// File: rtl/rz_uart_tx_arb.sv
// ============================================================================
// Module   : rz_uart_tx_arb
// Brief    : Round-robin arbiter sharing one rz_uart transmitter among NUM_REQ
//            requesters. It issues single-cycle tx_valid pulses and then locks
//            out further sends until the current frame has finished.
//            Optional macro RZ_UART_TX_ARB_PRIO_EN makes requester 0 high
//            priority.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rz_uart_tx_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          tx_clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_tx_valid,
    output logic [DATA_WIDTH-1:0]         uart_tx_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IW           = $clog2(NUM_REQ);
    localparam int FRAME_CYCLES = DATA_WIDTH + 6;
    localparam int HOLD_LEN     = FRAME_CYCLES + GAP_CYCLES;
    localparam int CW           = $clog2(HOLD_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_grant;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         w_winner;
    logic [IW-1:0]         w_next_ptr;
    logic                  w_any;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Candidates are scanned from the farthest to the nearest, so the last hit is the winner
    always_comb begin
        logic [IW-1:0] w_idx;
        w_idx      = '0;
        w_any      = 1'b0;
        w_winner   = '0;
        w_next_ptr = r_rr_ptr;
`ifdef RZ_UART_TX_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_any    = 1'b1;
            w_winner = '0;
        end else begin
            for (int k = NUM_REQ - 2; k >= 0; k--) begin
                w_idx = IW'(1 + (((r_rr_ptr == '0) ? 0 : int'(r_rr_ptr) - 1) + k) % (NUM_REQ - 1));
                if (req_valid[w_idx]) begin
                    w_any    = 1'b1;
                    w_winner = w_idx;
                end
            end
            if (w_any) begin
                w_next_ptr = (w_winner == IW'(NUM_REQ - 1)) ? IW'(1) : w_winner + 1'b1;
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        if (w_any) begin
            w_next_ptr = (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
`endif
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The ready term is gated by reset_n so the accept stays low while reset is held
    always_comb begin
        w_next_state = r_state;
        w_xfer       = 1'b0;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_any && reset_n) begin
                    req_ready    = NUM_REQ'(1) << w_winner;
                    w_xfer       = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE:   w_next_state = HOLD;
            HOLD:    if (r_cnt == '0) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_xfer) begin
                r_data   <= w_words[w_winner];
                r_grant  <= w_winner;
                r_rr_ptr <= w_next_ptr;
            end
            if (r_state == ISSUE) begin
                r_cnt <= CW'(HOLD_LEN - 1);
            end else if (r_state == HOLD && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign uart_tx_valid = (r_state == ISSUE);
    assign busy          = (r_state != IDLE);
    assign uart_tx_data  = r_data;
    assign grant_id      = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_rz_uart_tx_arb.sv
// ============================================================================
// Module   : tb_rz_uart_tx_arb
// Brief    : Directed self-checking bench for rz_uart_tx_arb (default params).
//            Honours RZ_UART_TX_ARB_PRIO_EN when it is defined.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rz_uart_tx_arb;

    logic        tx_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int rel_cyc  = 0;
    int first_g;
    int exp_seq [5];
    int tail_seq [4];

    int         pq_grant [$];
    logic [7:0] pq_data  [$];
    int         pq_cyc   [$];

    rz_uart_tx_arb dut (
        .tx_clk        (tx_clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #5 tx_clk = ~tx_clk;

    always @(negedge tx_clk) begin
        cyc = cyc + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (uart_tx_valid) begin
            pq_grant.push_back(int'(grant_id));
            pq_data.push_back(uart_tx_data);
            pq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        pq_grant.delete();
        pq_data.delete();
        pq_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_pulses(input int n);
        int t;
        t = 0;
        while (pq_data.size() < n && t < 300) begin
            @(negedge tx_clk);
            #1;
            t++;
        end
        check("pulse_count", pq_data.size(), n);
    endtask

    initial begin
`ifdef RZ_UART_TX_ARB_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
        first_g = 0;
`else
        exp_seq = '{0, 1, 2, 3, 0};
        first_g = 3;
`endif
        tail_seq = '{1, 2, 3, 1};

        // Reset with a request already pending
        reset_n   = 1'b0;
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'hA5, 8'h5C, 8'h00};
        repeat (2) @(negedge tx_clk);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_valid", uart_tx_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_grant", grant_id, 2'd0);
        check("rst_data",  uart_tx_data, 8'h00);

        // Single request from requester 2
        #2;
        clear_log();
        rel_cyc = cyc;
        reset_n = 1'b1;
        #1;
        check("ready_onehot", req_ready, 4'b0100);
        @(posedge tx_clk);
        #1 req_valid = 4'b0000;
        repeat (25) @(negedge tx_clk);
        #1;
        check("t1_pulses", pq_data.size(), 1);
        check("t1_data",   pq_data[0], 8'hA5);
        check("t1_grant",  pq_grant[0], 2);
        check("t1_first",  pq_cyc[0] - rel_cyc, 1);
        check("t1_busy",   busy_cnt, 17);

        // Wrap-around: rr_ptr=3, only requester 1; data changes during HOLD
        clear_log();
        req_valid = 4'b0010;
        @(posedge tx_clk);
        #1 req_valid = 4'b0000;
        repeat (4) @(negedge tx_clk);
        #1;
        req_data[15:8] = 8'h77;
        check("hold_data",  uart_tx_data, 8'h5C);
        check("hold_grant", grant_id, 2'd1);
        repeat (15) @(negedge tx_clk);
        #1;
        check("after_data",  uart_tx_data, 8'h5C);
        check("wrap_pulses", pq_data.size(), 1);
        check("wrap_grant",  pq_grant[0], 1);
        check("wrap_sent",   pq_data[0], 8'h5C);

        // rr_ptr must now be 2
        clear_log();
        req_valid = 4'b1110;
        @(posedge tx_clk);
        #1 req_valid = 4'b0000;
        repeat (3) @(negedge tx_clk);
        #1;
        check("ptr2_grant", pq_grant[0], 2);
        check("ptr2_data",  pq_data[0], 8'hA5);

        // Reset in the middle of HOLD
        repeat (16) @(negedge tx_clk);
        #1;
        clear_log();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        @(posedge tx_clk);
        repeat (5) @(negedge tx_clk);
        #1;
        check("pre_rst_grant", pq_grant[0], first_g);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", uart_tx_valid, 1'b0);
        check("mid_rst_busy",  busy, 1'b0);
        check("mid_rst_grant", grant_id, 2'd0);
        check("mid_rst_ready", req_ready, 4'b0000);
        check("mid_rst_data",  uart_tx_data, 8'h00);
        @(negedge tx_clk);
        #2;
        clear_log();
        rel_cyc = cyc;
        reset_n = 1'b1;

        // Continuous requests from everyone after reset
        wait_pulses(5);
        check("rr_first", pq_cyc[0] - rel_cyc, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_grant%0d", i), pq_grant[i], exp_seq[i]);
            check($sformatf("rr_data%0d", i), pq_data[i], 8'h10 + 8'(exp_seq[i]));
            if (i > 0) check($sformatf("rr_gap%0d", i), pq_cyc[i] - pq_cyc[i-1], 18);
        end

        // Requester 0 drops out
        clear_log();
        req_valid = 4'b1110;
        wait_pulses(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tail_grant%0d", i), pq_grant[i], tail_seq[i]);
        end

        req_valid = 4'b0000;
        repeat (20) @(negedge tx_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
